// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the fifo_ctrl block: controller state encoding.
// Optional error flags are enabled with FIFO_CTRL_ERR_STICKY_EN (see fifo_ctrl.sv).
package fifo_ctrl_pkg;

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_FULL   = 2'd2;

   typedef enum logic [1:0] {
      EMPTY  = ST_EMPTY,
      ACTIVE = ST_ACTIVE,
      FULL   = ST_FULL
   } ctrl_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Circular-buffer pointer: W-bit register that advances by one when inc is high.
// The MSB acts as the wrap bit when W = ADDR_W+1.
module fifo_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller sequencing a dual-port memory as a circular buffer.
// Define FIFO_CTRL_ERR_STICKY_EN to add sticky ovf_err/udf_err flags with an err_clr input.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 3,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
`ifdef FIFO_CTRL_ERR_STICKY_EN
   input  logic              err_clr,
   output logic              ovf_err,
   output logic              udf_err,
`endif
   output logic              w_en,
   output logic              r_en,
   output logic [ADDR_W-1:0] w_adrs,
   output logic [ADDR_W-1:0] r_adrs,
   output logic              r_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count
);

   localparam int            DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_CNT    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_CNT    = AE_LEVEL[ADDR_W:0];

   ctrl_state_t       state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              r_valid_q, r_valid_d;
   logic [ADDR_W:0]   wr_ptr, rd_ptr;
   logic              unused_wrap;

   fifo_ptr #(.W(ADDR_W + 1)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (w_en),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.W(ADDR_W + 1)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (r_en),
      .ptr   (rd_ptr)
   );

   // Wrap bits are kept for a full-width pointer but flags come from the FSM.
   assign unused_wrap = wr_ptr[ADDR_W] ^ rd_ptr[ADDR_W];

   assign full   = (state_q == FULL);
   assign empty  = (state_q == EMPTY);
   // Enables are held low while reset is asserted so no stray pulse reaches the memory.
   assign w_en   = push & ~full & ~reset;
   assign r_en   = pop & ~empty & ~reset;
   assign w_adrs = wr_ptr[ADDR_W-1:0];
   assign r_adrs = rd_ptr[ADDR_W-1:0];

   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign count        = count_q;
   assign r_valid      = r_valid_q;

   always_comb begin
      count_d   = count_q;
      state_d   = state_q;
      r_valid_d = r_en;
      case ({w_en, r_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      case (state_q)
         EMPTY: begin
            if (w_en) begin
               state_d = (count_d == DEPTH_CNT) ? FULL : ACTIVE;
            end
         end
         ACTIVE: begin
            if (count_d == DEPTH_CNT) begin
               state_d = FULL;
            end else if (count_d == '0) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (r_en) begin
               state_d = (count_d == '0) ? EMPTY : ACTIVE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= EMPTY;
         count_q   <= '0;
         r_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         r_valid_q <= r_valid_d;
      end
   end

`ifdef FIFO_CTRL_ERR_STICKY_EN
   logic ovf_err_q, ovf_err_d;
   logic udf_err_q, udf_err_d;

   // A new error in the same cycle as err_clr wins, so no event is lost.
   always_comb begin
      ovf_err_d = (ovf_err_q & ~err_clr) | (push & full);
      udf_err_d = (udf_err_q & ~err_clr) | (pop & empty);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_err_q <= 1'b0;
         udf_err_q <= 1'b0;
      end else begin
         ovf_err_q <= ovf_err_d;
         udf_err_q <= udf_err_d;
      end
   end

   assign ovf_err = ovf_err_q;
   assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed vector table plus reset and wrap sequences,
// with a small memory model checking read-data order.
module tb_fifo_ctrl;

   typedef struct {
      logic       push;
      logic       pop;
      logic       w_en;
      logic       r_en;
      logic [2:0] w_adrs;
      logic [2:0] r_adrs;
      logic [3:0] count;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       r_valid;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic       w_en, r_en, r_valid, full, empty, almost_full, almost_empty;
   logic [2:0] w_adrs, r_adrs;
   logic [3:0] count;
`ifdef FIFO_CTRL_ERR_STICKY_EN
   logic       err_clr = 1'b0;
   logic       ovf_err, udf_err;
`endif

   int compared = 0;
   int mismatched = 0;

   logic [7:0] mem [0:7];
   logic [7:0] rdata;
   logic [7:0] data_in = 8'd0;
   logic [7:0] sb [$];
   vec_t       tbl [$];

   fifo_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
`ifdef FIFO_CTRL_ERR_STICKY_EN
      .err_clr      (err_clr),
      .ovf_err      (ovf_err),
      .udf_err      (udf_err),
`endif
      .w_en         (w_en),
      .r_en         (r_en),
      .w_adrs       (w_adrs),
      .r_adrs       (r_adrs),
      .r_valid      (r_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
   );

   always #5 clk = ~clk;

   // Behavioural memory with 1-cycle read latency, driven by the controller.
   always @(posedge clk) begin
      if (w_en) mem[w_adrs] <= data_in;
      if (r_en) rdata <= mem[r_adrs];
   end

   function automatic vec_t mk(input int p, input int q, input int we, input int re,
                               input int wa, input int ra, input int cnt, input int fu,
                               input int em, input int af, input int ae, input int rv);
      vec_t v;
      v.push = 1'(p);    v.pop = 1'(q);
      v.w_en = 1'(we);   v.r_en = 1'(re);
      v.w_adrs = 3'(wa); v.r_adrs = 3'(ra);
      v.count = 4'(cnt);
      v.full = 1'(fu);   v.empty = 1'(em);
      v.af = 1'(af);     v.ae = 1'(ae);
      v.r_valid = 1'(rv);
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: enables/addresses checked before the edge, state after it.
   task automatic apply_stimulus(input vec_t v, input string tag);
      @(negedge clk);
      push = v.push;
      pop  = v.pop;
      #1;
      check_output({tag, ".w_en"},   32'(w_en),   32'(v.w_en));
      check_output({tag, ".r_en"},   32'(r_en),   32'(v.r_en));
      check_output({tag, ".w_adrs"}, 32'(w_adrs), 32'(v.w_adrs));
      check_output({tag, ".r_adrs"}, 32'(r_adrs), 32'(v.r_adrs));
      @(posedge clk);
      #1;
      if (v.r_en) begin
         if (sb.size() == 0) begin
            check_output({tag, ".sb_empty"}, 32'd1, 32'd0);
         end else begin
            check_output({tag, ".rdata"}, 32'(rdata), 32'(sb.pop_front()));
         end
      end
      if (v.w_en) begin
         sb.push_back(data_in);
         data_in = data_in + 8'd1;
      end
      check_output({tag, ".count"},   32'(count),        32'(v.count));
      check_output({tag, ".full"},    32'(full),         32'(v.full));
      check_output({tag, ".empty"},   32'(empty),        32'(v.empty));
      check_output({tag, ".af"},      32'(almost_full),  32'(v.af));
      check_output({tag, ".ae"},      32'(almost_empty), 32'(v.ae));
      check_output({tag, ".r_valid"}, 32'(r_valid),      32'(v.r_valid));
   endtask

   initial begin
      // Fill, overflow attempt, push+pop at full, drain, underflow, push+pop at empty.
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 0, 1, 0, i, 0, i + 1, (i == 7), 0, (i + 1 >= 6), (i + 1 <= 1), 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 7, 0, 0, 1, 0, 1));
      for (int i = 1; i < 8; i++)
         tbl.push_back(mk(0, 1, 0, 1, 0, i, 7 - i, 0, (i == 7), (7 - i >= 6), (7 - i <= 1), 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
      for (int i = 1; i < 4; i++)
         tbl.push_back(mk(1, 0, 1, 0, i, 0, i + 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 4, 0, 4, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1, 5, 1, 3, 0, 0, 0, 0, 1));

      #1;
      check_output("rst.count", 32'(count),        32'd0);
      check_output("rst.empty", 32'(empty),        32'd1);
      check_output("rst.full",  32'(full),         32'd0);
      check_output("rst.ae",    32'(almost_empty), 32'd1);
      check_output("rst.af",    32'(almost_full),  32'd0);
      #12;
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         apply_stimulus(tbl[i], $sformatf("vec%0d", i));

      // Reset mid-stream with count=3 and r_valid high; requests held active.
      push = 1'b1;
      pop  = 1'b1;
      reset = 1'b1;
      #1;
      check_output("midrst.count",   32'(count),        32'd0);
      check_output("midrst.empty",   32'(empty),        32'd1);
      check_output("midrst.full",    32'(full),         32'd0);
      check_output("midrst.r_valid", 32'(r_valid),      32'd0);
      check_output("midrst.ae",      32'(almost_empty), 32'd1);
      check_output("midrst.af",      32'(almost_full),  32'd0);
      check_output("midrst.w_en",    32'(w_en),         32'd0);
      check_output("midrst.r_en",    32'(r_en),         32'd0);
      sb.delete();
      #1;
      reset = 1'b0;
      apply_stimulus(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0), "postrst");

      // Wrap: 5 pushes total, 5 pops, then 6 pushes.
      for (int i = 1; i < 5; i++)
         apply_stimulus(mk(1, 0, 1, 0, i, 0, i + 1, 0, 0, 0, 0, 0), $sformatf("wrap_w%0d", i));
      for (int i = 0; i < 5; i++)
         apply_stimulus(mk(0, 1, 0, 1, 5, i, 4 - i, 0, (i == 4), 0, (4 - i <= 1), 1), $sformatf("wrap_r%0d", i));
      for (int i = 0; i < 6; i++)
         apply_stimulus(mk(1, 0, 1, 0, (5 + i) % 8, 5, i + 1, 0, 0, (i + 1 >= 6), (i + 1 <= 1), 0),
                        $sformatf("wrap_w2_%0d", i));

`ifdef FIFO_CTRL_ERR_STICKY_EN
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      sb.delete();
      for (int i = 0; i < 8; i++)
         apply_stimulus(mk(1, 0, 1, 0, i, 0, i + 1, (i == 7), 0, (i + 1 >= 6), (i + 1 <= 1), 0), "err_fill");
      apply_stimulus(mk(1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0), "err_ovf");
      check_output("ovf_err.set", 32'(ovf_err), 32'd1);
      apply_stimulus(mk(0, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0), "err_idle");
      check_output("ovf_err.hold", 32'(ovf_err), 32'd1);
      check_output("udf_err.idle", 32'(udf_err), 32'd0);
      for (int i = 0; i < 8; i++)
         apply_stimulus(mk(0, 1, 0, 1, 0, i, 7 - i, 0, (i == 7), (7 - i >= 6), (7 - i <= 1), 1), "err_drain");
      apply_stimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "err_udf");
      check_output("udf_err.set", 32'(udf_err), 32'd1);
      @(negedge clk);
      pop = 1'b0;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check_output("ovf_err.clr", 32'(ovf_err), 32'd0);
      check_output("udf_err.clr", 32'(udf_err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
